match_scheduler: RTL and testbench

MATCH_SCHEDULER -- requirements
Module: match_scheduler

---
 rtl/cw_pkg.sv | 18 +
 rtl/hold_timer.sv | 33 +++
 rtl/match_scheduler.sv | 136 +++++++++++++
 tb/tb_match_scheduler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cw_pkg.sv
// Shared types and constants for the match scheduler.
//   match_state_t : FSM state encoding (IDLE, SERVE, PLAY, HOLD, DONE)
//   SCORE_W       : width of each score counter
//   TIMER_W       : width of the post-point pause counter (PAUSE_CYCLES up to 255)
package cw_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } match_state_t;

  localparam int SCORE_W = 3;
  localparam int TIMER_W = 8;

endpackage

// File: rtl/hold_timer.sv
// Down-counter used for the pause after each point.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   load         : load load_value on the next edge (wins over count)
//   load_value   : value to load
//   count        : decrement by one on the next edge; holds at 0
//   zero         : high while the counter value is 0
module hold_timer
  import cw_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               count,
  output logic               zero
);

  logic [TIMER_W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/match_scheduler.sv
// Match sequencing for a two-player point game: serves, live play, post-point
// pause and match completion.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   soft_reset            : synchronous match restart (highest priority)
//   win_left, win_right   : one-cycle point pulses from the playfield
//   field_reset           : one-cycle pulse that re-centres the playfield
//   play_enable           : high while a point is live
//   score_left/right      : points won this match (saturate at WINS_TO_MATCH)
//   match_over            : high once a side has reached WINS_TO_MATCH
//   match_winner          : 0 = left, 1 = right; valid while match_over=1
module match_scheduler
  import cw_pkg::*;
#(
  parameter int PAUSE_CYCLES  = 8,
  parameter int WINS_TO_MATCH = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               soft_reset,
  input  logic               win_left,
  input  logic               win_right,
  output logic               field_reset,
  output logic               play_enable,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               match_over,
  output logic               match_winner
);

  localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WINS_TO_MATCH);
  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(PAUSE_CYCLES - 1);

  match_state_t       state_reg, state_next;
  logic [SCORE_W-1:0] score_left_reg, score_right_reg;
  logic               timer_load, timer_count, timer_zero;
  logic [TIMER_W-1:0] timer_load_value;

  // A point only counts when exactly one side scores during live play.
  logic single_win;
  assign single_win = (state_reg == PLAY) && (win_left ^ win_right) && !soft_reset;

  logic match_decided;
  assign match_decided = (score_left_reg == WIN_SCORE) || (score_right_reg == WIN_SCORE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (soft_reset) begin
      state_next = SERVE;
    end else begin
      case (state_reg)
        IDLE:  state_next = SERVE;
        SERVE: state_next = PLAY;
        PLAY: begin
          if (win_left && win_right) begin
            state_next = SERVE;          // simultaneous point is replayed
          end else if (win_left || win_right) begin
            state_next = HOLD;
          end
        end
        HOLD: begin
          if (timer_zero) begin
            state_next = match_decided ? DONE : SERVE;
          end
        end
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode (state only)
  always_comb begin
    field_reset  = 1'b0;
    play_enable  = 1'b0;
    match_over   = 1'b0;
    match_winner = 1'b0;
    case (state_reg)
      SERVE: field_reset = 1'b1;
      PLAY:  play_enable = 1'b1;
      DONE: begin
        match_over   = 1'b1;
        match_winner = (score_right_reg == WIN_SCORE);
      end
      default: ;
    endcase
  end

  // Score counters, saturating at the match target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_left_reg  <= '0;
      score_right_reg <= '0;
    end else if (soft_reset) begin
      score_left_reg  <= '0;
      score_right_reg <= '0;
    end else if (single_win) begin
      if (win_left && (score_left_reg < WIN_SCORE)) begin
        score_left_reg <= score_left_reg + 1'b1;
      end
      if (win_right && (score_right_reg < WIN_SCORE)) begin
        score_right_reg <= score_right_reg + 1'b1;
      end
    end
  end

  assign score_left  = score_left_reg;
  assign score_right = score_right_reg;

  // Pause timer control: soft restart clears it by loading zero.
  always_comb begin
    timer_load       = soft_reset || single_win;
    timer_load_value = soft_reset ? '0 : HOLD_LOAD;
    timer_count      = (state_reg == HOLD);
  end

  hold_timer u_hold_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (timer_load_value),
    .count      (timer_count),
    .zero       (timer_zero)
  );

endmodule

// File: tb/tb_match_scheduler.sv
module tb_match_scheduler;

  localparam int P = 8;
  localparam int W = 7;

  logic       clk;
  logic       reset_n;
  logic       soft_reset;
  logic       win_left;
  logic       win_right;
  logic       field_reset;
  logic       play_enable;
  logic [2:0] score_left;
  logic [2:0] score_right;
  logic       match_over;
  logic       match_winner;

  int n_assert = 0;
  int n_fail   = 0;

  match_scheduler #(.PAUSE_CYCLES(P), .WINS_TO_MATCH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .soft_reset   (soft_reset),
    .win_left     (win_left),
    .win_right    (win_right),
    .field_reset  (field_reset),
    .play_enable  (play_enable),
    .score_left   (score_left),
    .score_right  (score_right),
    .match_over   (match_over),
    .match_winner (match_winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic fr, input logic pe,
                         input logic [2:0] sl, input logic [2:0] sr,
                         input logic mo, input logic mw);
    chk({tag, ".field_reset"},  {7'd0, field_reset},  {7'd0, fr});
    chk({tag, ".play_enable"},  {7'd0, play_enable},  {7'd0, pe});
    chk({tag, ".score_left"},   {5'd0, score_left},   {5'd0, sl});
    chk({tag, ".score_right"},  {5'd0, score_right},  {5'd0, sr});
    chk({tag, ".match_over"},   {7'd0, match_over},   {7'd0, mo});
    chk({tag, ".match_winner"}, {7'd0, match_winner}, {7'd0, mw});
  endtask

  // Full point from PLAY back to PLAY: win edge, P hold cycles, serve, play.
  task automatic win_point(input bit left);
    win_left  = left;
    win_right = !left;
    step();
    win_left  = 1'b0;
    win_right = 1'b0;
    repeat (P) step();
    chk("point_serve", {7'd0, field_reset}, 8'd1);
    step();
    chk("point_play", {7'd0, play_enable}, 8'd1);
    $display("point %s: score %0d-%0d", left ? "left" : "right", score_left, score_right);
  endtask

  initial begin
    reset_n    = 1'b0;
    soft_reset = 1'b0;
    win_left   = 1'b0;
    win_right  = 1'b0;

    // Reset state
    repeat (2) step();
    chk_all("reset", 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    $display("reset held: all outputs checked");

    // Release: one IDLE cycle, one SERVE cycle, then PLAY
    reset_n = 1'b1;
    #1;
    chk_all("idle", 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    step();
    chk_all("serve", 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    step();
    chk_all("play", 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
    $display("reset release: idle -> serve -> play");

    // Single left point: P hold cycles with play disabled, serve on edge P+1
    win_left = 1'b1;
    step();
    win_left = 1'b0;
    chk_all("hold1", 1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0);
    for (int i = 2; i <= P; i++) begin
      step();
      chk("hold_play_enable", {7'd0, play_enable}, 8'd0);
      chk("hold_field_reset", {7'd0, field_reset}, 8'd0);
    end
    step();
    chk("hold_end_serve", {7'd0, field_reset}, 8'd1);
    step();
    chk("hold_end_play", {7'd0, play_enable}, 8'd1);
    $display("single point: score %0d-%0d", score_left, score_right);

    // Simultaneous point: replay, no score change, serve next edge
    win_left  = 1'b1;
    win_right = 1'b1;
    step();
    win_left  = 1'b0;
    win_right = 1'b0;
    chk_all("simul", 1'b1, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0);
    step();
    chk("simul_play", {7'd0, play_enable}, 8'd1);
    $display("simultaneous point: score %0d-%0d", score_left, score_right);

    // Soft restart during HOLD with score_left=3
    win_point(1'b1);
    win_left = 1'b1;
    step();
    win_left = 1'b0;
    step();
    chk_all("hold_sl3", 1'b0, 1'b0, 3'd3, 3'd0, 1'b0, 1'b0);
    soft_reset = 1'b1;
    win_left   = 1'b1;
    step();
    soft_reset = 1'b0;
    win_left   = 1'b0;
    chk_all("soft_hold", 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    step();
    chk("soft_hold_play", {7'd0, play_enable}, 8'd1);
    $display("soft restart in hold: score %0d-%0d", score_left, score_right);

    // Soft restart together with a win in PLAY: win discarded
    soft_reset = 1'b1;
    win_left   = 1'b1;
    step();
    soft_reset = 1'b0;
    win_left   = 1'b0;
    chk_all("soft_win", 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    step();
    chk("soft_win_play", {7'd0, play_enable}, 8'd1);
    $display("soft restart with win: score %0d-%0d", score_left, score_right);

    // Match end: 7 right points
    repeat (W - 1) win_point(1'b0);
    chk("sr6", {5'd0, score_right}, 8'd6);
    win_right = 1'b1;
    step();
    win_right = 1'b0;
    chk_all("last_point", 1'b0, 1'b0, 3'd0, 3'd7, 1'b0, 1'b0);
    repeat (P) step();
    chk_all("done", 1'b0, 1'b0, 3'd0, 3'd7, 1'b1, 1'b1);
    $display("match end: winner %0d score %0d-%0d", match_winner, score_left, score_right);

    // Win pulses in DONE are ignored, score saturated
    win_right = 1'b1;
    step();
    win_right = 1'b0;
    win_left  = 1'b1;
    step();
    win_left  = 1'b0;
    step();
    chk_all("done_ignore", 1'b0, 1'b0, 3'd0, 3'd7, 1'b1, 1'b1);
    $display("done ignores wins: score %0d-%0d", score_left, score_right);

    // Soft restart from DONE
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    chk_all("soft_done", 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    step();
    chk("soft_done_play", {7'd0, play_enable}, 8'd1);
    $display("soft restart from done: score %0d-%0d", score_left, score_right);

    // Asynchronous reset mid-PLAY with score_left=2
    win_point(1'b1);
    win_point(1'b1);
    chk("sl2", {5'd0, score_left}, 8'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_reset", 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    step();
    chk("async_reset_fr", {7'd0, field_reset}, 8'd0);
    reset_n = 1'b1;
    #1;
    chk("rerelease_idle", {7'd0, field_reset}, 8'd0);
    step();
    chk_all("rerelease_serve", 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    step();
    chk("rerelease_play", {7'd0, play_enable}, 8'd1);
    $display("async reset mid-play: score %0d-%0d", score_left, score_right);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
